// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding for the SPI master.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_t;
endpackage

// File: rtl/clock_divider.sv
// clock_divider: free-running divider producing one-cycle rise/fall strobes per Divisor clk.
module clock_divider #(
    parameter int Divisor = 4
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out,
    output logic clk_pos,
    output logic clk_neg
);
    localparam int CntW = $clog2(Divisor);
    logic [CntW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (rst || cnt_q == CntW'(Divisor - 1)) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) cnt_q <= cnt_d;
    assign clk_pos = cnt_q == CntW'(Divisor - 1);
    assign clk_neg = cnt_q == CntW'(Divisor / 2 - 1);
    assign clk_out = cnt_q >= CntW'(Divisor / 2);
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, one Width-bit word per transfer, MSB first.
module spi_master
    import spi_pkg::*;
#(
    parameter int Divisor = 4,
    parameter int Width   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [Width-1:0] tx_data,
    output logic             rx_valid,
    output logic [Width-1:0] rx_data,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             cs_n
);
    localparam int BlW = $clog2(Width + 1);
    spi_state_t       state_q, state_d;
    logic [Width-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
    logic [BlW-1:0]   bits_left_q, bits_left_d;
    logic             sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d, rx_valid_q, rx_valid_d;
    logic             clk_pos, clk_neg;
    logic [Width:0]   tx_next, rx_next;

    // Holding the divider in reset while idle restarts SCK phase on every transfer.
    clock_divider #(.Divisor(Divisor)) u_div (
        .clk(clk),
        .rst(rst || state_q == IDLE),
        .clk_out(),
        .clk_pos(clk_pos),
        .clk_neg(clk_neg)
    );

    // Widened by one bit so the shifts also elaborate for Width == 1.
    assign tx_next = {tx_sr_q, 1'b0};
    assign rx_next = {rx_sr_q, miso};

    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        bits_left_d = bits_left_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        rx_valid_d  = 1'b0;
        case (state_q)
            IDLE: if (tx_valid) begin
                tx_sr_d     = tx_data;
                bits_left_d = BlW'(Width);
                mosi_d      = tx_data[Width-1];
                cs_n_d      = 1'b0;
                state_d     = SETUP;
            end
            SETUP: if (clk_pos) begin
                sck_d   = 1'b1;
                rx_sr_d = rx_next[Width-1:0];
                state_d = SHIFT;
            end
            SHIFT: if (clk_pos) begin
                sck_d   = 1'b1;
                rx_sr_d = rx_next[Width-1:0];
            end else if (clk_neg) begin
                sck_d = 1'b0;
                if (bits_left_q == BlW'(1)) begin
                    state_d = HOLD;
                end else begin
                    tx_sr_d     = tx_next[Width-1:0];
                    mosi_d      = tx_next[Width-1];
                    bits_left_d = bits_left_q - 1'b1;
                end
            end
            HOLD: if (clk_pos) begin
                cs_n_d     = 1'b1;
                rx_data_d  = rx_sr_q;
                rx_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d     = IDLE;
            tx_sr_d     = '0;
            rx_sr_d     = '0;
            rx_data_d   = '0;
            bits_left_d = '0;
            sck_d       = 1'b0;
            mosi_d      = 1'b0;
            cs_n_d      = 1'b1;
            rx_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        tx_sr_q     <= tx_sr_d;
        rx_sr_q     <= rx_sr_d;
        rx_data_q   <= rx_data_d;
        bits_left_q <= bits_left_d;
        sck_q       <= sck_d;
        mosi_q      <= mosi_d;
        cs_n_q      <= cs_n_d;
        rx_valid_q  <= rx_valid_d;
    end

    assign tx_ready = state_q == IDLE;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: three SPI master configurations checked each cycle against a timeline model.
module tb_spi_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  tv = '0, rdy, rxv, sck, mosi, cs_n, miso;
    logic [31:0] txd [3] = '{default: '0};
    logic [31:0] rxd [3];
    logic [7:0]  rxd0, rxd1;
    logic [0:0]  rxd2;
    logic        loop = 1'b1, sbit;
    logic [7:0]  sw = '0;
    int          sfall = 0, sbase = 0, sk;
    int          checks = 0, errors = 0;

    localparam int DV [3] = '{4, 2, 3};
    localparam int WD [3] = '{8, 8, 1};

    always #5 clk = ~clk;

    spi_master #(.Divisor(4), .Width(8)) u0 (
        .clk(clk), .rst(rst), .tx_valid(tv[0]), .tx_ready(rdy[0]), .tx_data(txd[0][7:0]),
        .rx_valid(rxv[0]), .rx_data(rxd0), .sck(sck[0]), .mosi(mosi[0]), .miso(miso[0]), .cs_n(cs_n[0]));
    spi_master #(.Divisor(2), .Width(8)) u1 (
        .clk(clk), .rst(rst), .tx_valid(tv[1]), .tx_ready(rdy[1]), .tx_data(txd[1][7:0]),
        .rx_valid(rxv[1]), .rx_data(rxd1), .sck(sck[1]), .mosi(mosi[1]), .miso(miso[1]), .cs_n(cs_n[1]));
    spi_master #(.Divisor(3), .Width(1)) u2 (
        .clk(clk), .rst(rst), .tx_valid(tv[2]), .tx_ready(rdy[2]), .tx_data(txd[2][0:0]),
        .rx_valid(rxv[2]), .rx_data(rxd2), .sck(sck[2]), .mosi(mosi[2]), .miso(miso[2]), .cs_n(cs_n[2]));

    assign rxd[0] = {24'b0, rxd0};
    assign rxd[1] = {24'b0, rxd1};
    assign rxd[2] = {31'b0, rxd2};

    // Mode-0 slave on instance 0: presents its MSB at select, advances on each SCK fall.
    always @(negedge sck[0]) sfall++;
    always_comb begin
        sk   = sfall - sbase;
        sbit = (sk >= 0 && sk < 8) ? sw[7-sk] : 1'b0;
    end
    assign miso[0] = loop ? mosi[0] : sbit;
    assign miso[1] = mosi[1];
    assign miso[2] = 1'b0;

    task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, a, e);
        end
    endtask

    // Model: n counts cycles since acceptance; L=(W+1)*D cycles with cs_n low, then an
    // idle cycle carrying rx_valid. SCK is high for D/2 cycles after each of W rises at n=j*D+1.
    int          n [3] = '{default: 0};
    int          rises [3] = '{default: 0};
    int          rxv_cnt [3] = '{default: 0};
    logic [31:0] tx_m [3], rx_acc [3], rx_hold [3];
    logic [2:0]  mosi_hold = '0, sck_prev = '0;
    logic        chk_en = 1'b0, act, e_sck, e_mosi;
    int          cd, cw, cl, ch, cn, bi;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            cd = DV[i];
            cw = WD[i];
            cl = (cw + 1) * cd;
            ch = cd / 2;
            cn = n[i];
            if (rst) begin
                n[i] = 0;
                rx_hold[i] = '0;
                mosi_hold[i] = 1'b0;
                chk_en = 1'b1;
            end else begin
                act = cn >= 1 && cn <= cl;
                e_sck = act && cn > cd && (cn - 1) % cd < ch && (cn - 1) / cd <= cw;
                bi = (cn <= ch) ? 0 : (((cn - ch - 1) / cd < cw - 1) ? (cn - ch - 1) / cd : cw - 1);
                e_mosi = act ? tx_m[i][cw-1-bi] : mosi_hold[i];
                if (chk_en) begin
                    chk("sck", i, sck[i], e_sck);
                    chk("cs_n", i, cs_n[i], !act);
                    chk("tx_ready", i, rdy[i], !act);
                    chk("rx_valid", i, rxv[i], cn == cl + 1);
                    chk("mosi", i, mosi[i], e_mosi);
                    chk("rx_data", i, rxd[i], rx_hold[i]);
                end
                if (act && cn % cd == 0 && cn / cd <= cw) rx_acc[i][cw-cn/cd] = miso[i];
                if (sck[i] && !sck_prev[i]) rises[i]++;
                if (rxv[i]) rxv_cnt[i]++;
                if (cn == 0 || cn == cl + 1) begin
                    n[i] = tv[i] ? 1 : 0;
                    if (tv[i]) begin
                        tx_m[i] = txd[i];
                        rx_acc[i] = '0;
                    end
                end else if (cn == cl) begin
                    n[i] = cl + 1;
                    rx_hold[i] = rx_acc[i];
                    mosi_hold[i] = tx_m[i][0];
                end else begin
                    n[i] = cn + 1;
                end
            end
            sck_prev[i] = sck[i];
        end
    end

    task automatic send(input int i, input logic [31:0] d);
        @(posedge clk) #1;
        txd[i] = d;
        tv[i] = 1'b1;
        @(posedge clk) #1;
        tv[i] = 1'b0;
    endtask

    task automatic wait_rx(input int i, input string nm);
        logic seen = 1'b0;
        repeat (400) if (!seen) begin
            @(negedge clk);
            seen = rxv[i];
        end
        chk(nm, i, seen, 1'b1);
    endtask

    int r, v;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", 0, cs_n[0], 1'b1);
        chk("rst_sck", 0, sck[0], 1'b0);
        chk("rst_ready", 0, rdy[0], 1'b1);
        chk("rst_rx_data", 0, rxd[0], 0);
        chk("rst_mosi", 0, mosi[0], 1'b0);

        r = rises[0];
        v = rxv_cnt[0];
        send(0, 32'hA5);
        wait_rx(0, "a5_done");
        chk("a5_rx", 0, rxd[0], 32'hA5);
        repeat (3) @(negedge clk);
        chk("a5_rises", 0, rises[0] - r, 8);
        chk("a5_pulses", 0, rxv_cnt[0] - v, 1);

        loop = 1'b0;
        sw = 8'h3C;
        sbase = sfall;
        send(0, 32'hFF);
        wait_rx(0, "slave_done");
        chk("slave_rx", 0, rxd[0], 32'h3C);
        repeat (3) @(negedge clk);
        loop = 1'b1;

        v = rxv_cnt[0];
        send(0, 32'h5A);
        repeat (12) @(posedge clk);
        #1 txd[0] = 32'hEE;
        tv[0] = 1'b1;
        @(posedge clk) #1 tv[0] = 1'b0;
        wait_rx(0, "ign_done");
        chk("ign_rx", 0, rxd[0], 32'h5A);
        repeat (40) @(negedge clk);
        chk("ign_cs_n", 0, cs_n[0], 1'b1);
        chk("ign_pulses", 0, rxv_cnt[0] - v, 1);

        r = rises[0];
        v = rxv_cnt[0];
        send(0, 32'hC3);
        repeat (200) if (rises[0] - r < 4) @(negedge clk);
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        chk("abort_cs_n", 0, cs_n[0], 1'b1);
        chk("abort_sck", 0, sck[0], 1'b0);
        chk("abort_ready", 0, rdy[0], 1'b1);
        chk("abort_rises", 0, rises[0] - r, 4);
        repeat (40) @(negedge clk);
        chk("abort_pulses", 0, rxv_cnt[0] - v, 0);
        send(0, 32'h96);
        wait_rx(0, "after_abort_done");
        chk("after_abort_rx", 0, rxd[0], 32'h96);

        r = rises[1];
        @(posedge clk) #1;
        txd[1] = 32'h01;
        tv[1] = 1'b1;
        @(posedge clk) #1 txd[1] = 32'h80;
        wait_rx(1, "b2b_w0");
        chk("b2b_rx0", 1, rxd[1], 32'h01);
        @(posedge clk) #1 txd[1] = 32'h55;
        wait_rx(1, "b2b_w1");
        chk("b2b_rx1", 1, rxd[1], 32'h80);
        @(posedge clk) #1 tv[1] = 1'b0;
        wait_rx(1, "b2b_w2");
        chk("b2b_rx2", 1, rxd[1], 32'h55);
        repeat (20) @(negedge clk);
        chk("b2b_rises", 1, rises[1] - r, 24);
        chk("b2b_pulses", 1, rxv_cnt[1], 3);

        r = rises[2];
        send(2, 32'h1);
        wait_rx(2, "w1_done");
        chk("w1_rx", 2, rxd[2], 0);
        repeat (3) @(negedge clk);
        chk("w1_rises", 2, rises[2] - r, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
